// File: rtl/cpu_step_ctrl_if.sv
// Command bus into the run/step/breakpoint controller.
//   cmd_valid : command strobe (master -> slave)
//   cmd_ready : always 1, commands are consumed the cycle they arrive
//   cmd_op    : 0=RUN, 1=STEP, 2=HALT, 3=SET_BP
//   cmd_idx   : breakpoint index for SET_BP
//   cmd_arg   : SET_BP payload, bit PC_W = enable, [PC_W-1:0] = PC
interface cpu_step_ctrl_if #(
  parameter int PC_W = 11
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [2:0]      cmd_idx;
  logic [PC_W:0]   cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_idx, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_idx, cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint controller for the multi-cycle CPU. Produces the CPU
// clock enable in whole-instruction units of CYCLES_PER_INSTR clocks, with
// free-run, single-step, HALT and PC breakpoints, plus a retired count.
// Optional feature macro: CPU_TRACE_EN (boundary PC trace buffer).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cmd           : command bus (cpu_step_ctrl_if.slave)
//   pc_in         : CPU PC, sampled at instruction boundaries
//   cpu_en        : CPU clock enable
//   instr_done    : registered pulse one clock after each boundary
//   halted        : controller is HALTED
//   bp_hit        : sticky breakpoint-halt flag, bp_hit_idx = matching index
//   cmd_err       : registered pulse for RUN/STEP while not halted or bad index
//   retired_cnt   : retired instruction count (wraps)
//   trace_rd_idx  : trace read index, 0 = newest
//   trace_pc      : trace read data (0 when CPU_TRACE_EN is not defined)
module cpu_step_ctrl #(
  parameter int CYCLES_PER_INSTR = 7,
  parameter int PC_W             = 11,
  parameter int NUM_BP           = 2,
  parameter bit RUN_ON_RESET     = 1'b1,
  parameter int TRACE_DEPTH      = 8,
  localparam int TW              = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_step_ctrl_if.slave    cmd,
  input  logic [PC_W-1:0]   pc_in,
  output logic              cpu_en,
  output logic              instr_done,
  output logic              halted,
  output logic              bp_hit,
  output logic [2:0]        bp_hit_idx,
  output logic              cmd_err,
  output logic [31:0]       retired_cnt,
  input  logic [TW-1:0]     trace_rd_idx,
  output logic [PC_W-1:0]   trace_pc
);

  localparam int PH_W = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYCLES_PER_INSTR - 1);

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUNNING,
    ST_STEPPING
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN    = 2'd0,
    OP_STEP   = 2'd1,
    OP_HALT   = 2'd2,
    OP_SET_BP = 2'd3
  } op_t;

  localparam state_t ST_RESET = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase;
  logic              halt_pend;
  logic [NUM_BP-1:0] bp_en;
  logic [PC_W-1:0]   bp_pc [NUM_BP];

  logic              is_run, is_step, is_halt, is_set_bp, bad_idx;
  logic              boundary, stop_run;
  logic              bp_match;
  logic [2:0]        bp_match_idx;

  assign is_run    = cmd.cmd_valid && (cmd.cmd_op == OP_RUN);
  assign is_step   = cmd.cmd_valid && (cmd.cmd_op == OP_STEP);
  assign is_halt   = cmd.cmd_valid && (cmd.cmd_op == OP_HALT);
  assign is_set_bp = cmd.cmd_valid && (cmd.cmd_op == OP_SET_BP);
  assign bad_idx   = is_set_bp && (32'(cmd.cmd_idx) >= NUM_BP);

  assign boundary  = cpu_en && (phase == PH_LAST);
  // A HALT arriving on the boundary cycle itself stops at that boundary.
  assign stop_run  = halt_pend || is_halt || bp_match;

  // Lowest enabled breakpoint matching the current PC.
  always_comb begin
    bp_match     = 1'b0;
    bp_match_idx = '0;
    for (int unsigned k = 0; k < NUM_BP; k++) begin
      if (!bp_match && bp_en[k] && (bp_pc[k] == pc_in)) begin
        bp_match     = 1'b1;
        bp_match_idx = 3'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALTED: begin
        if (is_run)       state_d = ST_RUNNING;
        else if (is_step) state_d = ST_STEPPING;
      end
      ST_RUNNING: begin
        if (boundary && stop_run) state_d = ST_HALTED;
      end
      ST_STEPPING: begin
        if (boundary) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cpu_en        = (state_q != ST_HALTED);
    halted        = (state_q == ST_HALTED);
    cmd.cmd_ready = 1'b1;
  end

  // Phase, counters, flags and breakpoint registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= '0;
      retired_cnt <= '0;
      instr_done  <= 1'b0;
      cmd_err     <= 1'b0;
      halt_pend   <= 1'b0;
      bp_hit      <= 1'b0;
      bp_hit_idx  <= '0;
      bp_en       <= '0;
      for (int unsigned k = 0; k < NUM_BP; k++) bp_pc[k] <= '0;
    end else begin
      instr_done <= boundary;
      cmd_err    <= ((is_run || is_step) && (state_q != ST_HALTED)) || bad_idx;

      if (cpu_en) phase <= boundary ? '0 : phase + 1'b1;
      if (boundary) retired_cnt <= retired_cnt + 32'd1;

      // HALT is only remembered while free-running; in STEPPING it is absorbed.
      if (state_q == ST_RUNNING) begin
        if (boundary && stop_run) halt_pend <= 1'b0;
        else if (is_halt)         halt_pend <= 1'b1;
      end

      if ((state_q == ST_HALTED) && (is_run || is_step)) begin
        bp_hit <= 1'b0;
      end else if ((state_q == ST_RUNNING) && boundary && bp_match) begin
        bp_hit     <= 1'b1;
        bp_hit_idx <= bp_match_idx;
      end

      if (is_set_bp) begin
        for (int unsigned k = 0; k < NUM_BP; k++) begin
          if (cmd.cmd_idx == 3'(k)) begin
            bp_en[k] <= cmd.cmd_arg[PC_W];
            bp_pc[k] <= cmd.cmd_arg[PC_W-1:0];
          end
        end
      end
    end
  end

`ifdef CPU_TRACE_EN
  logic [PC_W-1:0] trace_mem [TRACE_DEPTH];
  logic [TW-1:0]   trace_wptr;
  logic [TW-1:0]   trace_ridx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_wptr <= '0;
      for (int unsigned k = 0; k < TRACE_DEPTH; k++) trace_mem[k] <= '0;
    end else if (boundary) begin
      trace_mem[trace_wptr] <= pc_in;
      trace_wptr            <= trace_wptr + 1'b1;
    end
  end

  // Power-of-two depth: TW-bit arithmetic gives the modulo for free.
  assign trace_ridx = trace_wptr - TW'(1) - trace_rd_idx;
  assign trace_pc   = trace_mem[trace_ridx];
`else
  logic trace_unused;
  assign trace_unused = ^trace_rd_idx;
  assign trace_pc     = '0;
`endif

endmodule
